// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, signed (MULT) or unsigned (MULTU).
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   start     - request a multiply, accepted only while idle
//   is_signed - 1 = two's-complement operands, sampled with start
//   A, B      - multiplicand / multiplier, sampled with start
//   product   - registered 2*WIDTH result {HI, LO}, held until the next result
//   busy      - operation in progress
//   done      - one-cycle pulse when product is updated
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
   state_t               r_state, w_next;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_prod;
   logic                 r_neg;
   logic                 r_done;
   logic                 w_a_neg, w_b_neg, w_accept;
   logic [WIDTH-1:0]     w_a_mag, w_b_mag;
   logic [WIDTH:0]       w_sum;
   assign w_a_neg  = is_signed & A[WIDTH-1];
   assign w_b_neg  = is_signed & B[WIDTH-1];
   // the most-negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1)
   assign w_a_mag  = w_a_neg ? -A : A;
   assign w_b_mag  = w_b_neg ? -B : B;
   assign w_accept = (r_state == S_IDLE) & start;
   // upper half plus multiplicand keeps its carry in bit WIDTH, which shifts back into the top
   assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE)
         w_next = start ? S_RUN : S_IDLE;
      else if (r_state == S_RUN)
         w_next = (r_cnt == CW'(WIDTH-1)) ? S_FIN : S_RUN;
      else
         w_next = S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_prod  <= '0;
         r_neg   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= (r_state == S_FIN);
         if (w_accept) begin
            r_mcand <= w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
            r_cnt   <= '0;
            r_neg   <= w_a_neg ^ w_b_neg;
         end
         if (r_state == S_RUN) begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
         end
         if (r_state == S_FIN)
            r_prod <= r_neg ? -r_acc : r_acc;
      end
   end
   assign product = r_prod;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: self-checking bench for seq_multiplier at WIDTH=32.
module tb_seq_multiplier;
   localparam int W  = 32;
   localparam int PW = 2*W;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          is_signed = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [PW-1:0] product;
   logic          busy, done;
   int            checks = 0;
   int            errors = 0;
   seq_multiplier #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .A(A), .B(B), .product(product), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic          s;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [PW-1:0] p;
   } vec_t;
   vec_t tv[10];
   function automatic logic [PW-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [PW-1:0] ea, eb;
      ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ea * eb;
   endfunction
   function automatic logic [W-1:0] pick();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return '0;
      if (r == 1) return W'(1);
      if (r == 2) return '1;
      if (r == 3) return {1'b1, {(W-1){1'b0}}};
      return W'({$urandom, $urandom});
   endfunction
   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // drive a request so that it is sampled on the next rising edge, then scramble the inputs
   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; is_signed = s; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0; is_signed = 1'($urandom); A = W'($urandom); B = W'($urandom);
   endtask
   // count edges after the accepting edge until done; busy must stay high and product frozen meanwhile
   task automatic wait_done(input logic [PW-1:0] prev, output int lat, output logic ok);
      lat = 0;
      ok = 1'b1;
      for (int k = 1; k <= W + 4; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
         if (!busy || product !== prev) ok = 1'b0;
      end
   endtask
   task automatic run(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] exp);
      int lat;
      logic ok;
      logic [PW-1:0] prev;
      issue(s, a, b);
      prev = product;
      wait_done(prev, lat, ok);
      chk({nm, "_lat"}, PW'(lat), PW'(W + 1));
      chk({nm, "_prod"}, product, exp);
      chk({nm, "_run"}, PW'(ok), PW'(1));
      chk({nm, "_busy_done"}, PW'(busy), PW'(0));
      @(posedge clk); #1;
      chk({nm, "_pulse"}, PW'(done), PW'(0));
   endtask
   initial begin
      int lat, nd, dat;
      logic ok;
      logic [PW-1:0] prev;
      tv[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
      tv[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFFFFFFFFF1};
      tv[2] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
      tv[3] = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
      tv[4] = '{1'b0, 32'h00000000, 32'h12345678, 64'h0000000000000000};
      tv[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000};
      tv[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
      tv[7] = '{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000};
      tv[8] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
      tv[9] = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE};
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_prod", product, '0);
      chk("rst_busy", PW'(busy), PW'(0));
      chk("rst_done", PW'(done), PW'(0));
      // first edge after reset release accepts start
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1; is_signed = 1'b0; A = 32'd9; B = 32'd11;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(product, lat, ok);
      chk("first_lat", PW'(lat), PW'(W + 1));
      chk("first_prod", product, 64'd99);
      // directed table
      for (int i = 0; i < 10; i++)
         run($sformatf("tv%0d", i), tv[i].s, tv[i].a, tv[i].b, tv[i].p);
      // start while busy is dropped
      issue(1'b0, 32'd7, 32'd6);
      nd = 0;
      dat = 0;
      for (int k = 1; k <= W + 6; k++) begin
         @(negedge clk);
         start = (k == 5);
         A = (k == 5) ? 32'd2 : A;
         B = (k == 5) ? 32'd2 : B;
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            nd++;
            dat = k;
         end
      end
      chk("drop_ndone", PW'(nd), PW'(1));
      chk("drop_at", PW'(dat), PW'(W + 1));
      chk("drop_prod", product, 64'd42);
      // back-to-back: second start in the done cycle
      issue(1'b0, 32'd3, 32'd4);
      wait_done(product, lat, ok);
      chk("b2b1_lat", PW'(lat), PW'(W + 1));
      chk("b2b1_prod", product, 64'd12);
      issue(1'b0, 32'd5, 32'd6);
      wait_done(64'd12, lat, ok);
      chk("b2b2_hold", PW'(ok), PW'(1));
      chk("b2b2_lat", PW'(lat), PW'(W + 1));
      chk("b2b2_prod", product, 64'd30);
      // reset mid-operation, with start presented on the reset edge
      issue(1'b1, 32'hFFFFFFF0, 32'h00000011);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; start = 1'b1; A = 32'd8; B = 32'd8;
      @(posedge clk); #1;
      chk("abort_busy", PW'(busy), PW'(0));
      chk("abort_done", PW'(done), PW'(0));
      chk("abort_prod", product, '0);
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle", PW'(busy), PW'(0));
      chk("abort_nodone", PW'(done), PW'(0));
      run("after_abort", 1'b0, 32'd2, 32'd3, 64'd6);
      // randomized regression against the arithmetic reference
      for (int i = 0; i < 600; i++) begin
         logic s;
         logic [W-1:0] a, b;
         s = (i >= 300);
         a = pick();
         b = pick();
         issue(s, a, b);
         wait_done(product, lat, ok);
         checks++;
         if (lat != W + 1 || !ok || product !== ref_mul(s, a, b)) begin
            errors++;
            $display("FAIL rnd%0d s=%0d a=%0h b=%0h: got %0h lat %0d expected %0h lat %0d",
                     i, s, a, b, product, lat, ref_mul(s, a, b), W + 1);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
